// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and saturation limits for the FIR output path
package fir_pkg;
  localparam int FIR_OUT_W = 18;
  localparam int SAMPLE_W = 8;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO that accepts a write into a full FIFO when a read frees a slot the same cycle
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, rd, wr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd = rd_en && !empty;
  assign wr = wr_en && (!full || rd);
  assign drop = wr_en && !wr;
  assign rd_data = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
  // pointers wrap for free because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: rounds, saturates and buffers 18-bit FIR results as 8-bit samples
module fir_out_fifo import fir_pkg::*; #(
  parameter int SHIFT = 6,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FIR_OUT_W-1:0]     Din,
  input  logic                     din_valid,
  output logic [SAMPLE_W-1:0]      dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [15:0]              sat_cnt
);
  localparam logic signed [FIR_OUT_W:0] HI = SAT_MAX;
  localparam logic signed [FIR_OUT_W:0] LO = SAT_MIN;
  localparam logic signed [FIR_OUT_W:0] RND = 1 << (SHIFT - 1);
  logic signed [FIR_OUT_W:0] sum, r;
  logic hi, lo, s1_valid, empty, drop;
  logic [SAMPLE_W-1:0] clip, s1_data;
  // one extra bit keeps the rounding add from wrapping at full-scale positive input
  assign sum = $signed({Din[FIR_OUT_W-1], Din}) + RND;
  assign r = sum >>> SHIFT;
  assign hi = r > HI;
  assign lo = r < LO;
  assign clip = hi ? SAMPLE_W'(SAT_MAX) : lo ? SAMPLE_W'(SAT_MIN) : r[SAMPLE_W-1:0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      sat_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      s1_valid <= din_valid;
      s1_data <= clip;
      if (din_valid && (hi || lo) && sat_cnt != '1) sat_cnt <= sat_cnt + 1'b1;
      overflow <= drop || (overflow && !ovf_clr);
    end
  sync_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(s1_valid),
    .wr_data(s1_data),
    .rd_en(dout_ready),
    .rd_data(dout),
    .count(count),
    .empty(empty),
    .drop(drop)
  );
  assign dout_valid = !empty;
endmodule

// File: tb/tb_fir_out_fifo.sv
// tb_fir_out_fifo: directed stimulus checked against a queue model and hand-computed values
module tb_fir_out_fifo;
  localparam int SHIFT = 6;
  localparam int DEPTH = 8;
  logic clk = 0, reset = 1, din_valid = 0, dout_ready = 0, ovf_clr = 0;
  logic [17:0] Din = '0;
  logic [7:0] dout;
  logic dout_valid, overflow;
  logic [3:0] count;
  logic [15:0] sat_cnt;
  int passed = 0, total = 0;
  logic [7:0] q[$];
  bit m_s1v = 0, m_ovf = 0;
  logic [7:0] m_s1d = '0;
  int m_sat = 0;

  always #5 clk = ~clk;

  fir_out_fifo #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Din(Din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .count(count), .overflow(overflow), .ovf_clr(ovf_clr), .sat_cnt(sat_cnt)
  );

  function automatic int round_shift(int d);
    real x;
    x = $floor((d + 2.0 ** (SHIFT - 1)) / (2.0 ** SHIFT));
    return int'(x);
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // model: FIFO as a queue, stage 1 as a single pending sample
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_s1v = 0;
      m_ovf = 0;
      m_sat = 0;
    end else begin
      bit rd, drop;
      int r;
      rd = q.size() > 0 && dout_ready;
      drop = m_s1v && q.size() == DEPTH && !rd;
      if (rd) void'(q.pop_front());
      if (m_s1v && !drop) q.push_back(m_s1d);
      m_ovf = drop || (m_ovf && !ovf_clr);
      r = round_shift(int'($signed(Din)));
      if (din_valid && (r > 127 || r < -128) && m_sat < 65535) m_sat++;
      m_s1d = r > 127 ? 8'h7F : r < -128 ? 8'h80 : 8'(r);
      m_s1v = din_valid;
    end
  end

  always @(negedge clk)
    if (reset) begin
      chk("count", int'(count), q.size());
      chk("dout_valid", int'(dout_valid), int'(q.size() != 0));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("sat_cnt", int'(sat_cnt), m_sat);
      if (q.size() != 0) chk("dout", int'(dout), int'(q[0]));
    end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(int d);
    Din = 18'(d);
    din_valid = 1;
    cyc();
    din_valid = 0;
  endtask

  task automatic pop(string name, int exp);
    chk(name, int'(dout), exp);
    chk({name, "_valid"}, int'(dout_valid), 1);
    dout_ready = 1;
    cyc();
    dout_ready = 0;
  endtask

  initial begin
    #1 reset = 0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    cyc(2);
    reset = 1;
    cyc(2);
    send(64); send(100); send(-96); send(31);
    cyc(2);
    chk("round_count", int'(count), 4);
    pop("round_64", 8'h01); pop("round_100", 8'h02); pop("round_m96", 8'hFF); pop("round_31", 8'h00);
    chk("round_sat_cnt", int'(sat_cnt), 0);
    send(20000); send(-20000);
    cyc(2);
    pop("sat_pos", 8'h7F); pop("sat_neg", 8'h80);
    chk("sat_cnt_2", int'(sat_cnt), 2);
    for (int k = 1; k <= 10; k++) send(k * 64);
    cyc(2);
    chk("ovf_count", int'(count), 8);
    chk("ovf_flag", int'(overflow), 1);
    for (int k = 1; k <= 8; k++) pop($sformatf("ovf_drain%0d", k), k);
    chk("ovf_empty", int'(count), 0);
    ovf_clr = 1;
    cyc();
    ovf_clr = 0;
    chk("ovf_clr_alone", int'(overflow), 0);
    for (int k = 11; k <= 18; k++) send(k * 64);
    cyc(2);
    chk("full_count", int'(count), 8);
    Din = 18'(19 * 64);
    din_valid = 1;
    cyc();
    dout_ready = 1;
    for (int k = 20; k <= 24; k++) begin
      Din = 18'(k * 64);
      cyc();
    end
    din_valid = 0;
    cyc();
    dout_ready = 0;
    chk("rw_full_count", int'(count), 8);
    chk("rw_full_ovf", int'(overflow), 0);
    for (int k = 17; k <= 24; k++) pop($sformatf("rw_order%0d", k), k);
    for (int k = 1; k <= 8; k++) send(k * 64);
    cyc(2);
    Din = 18'(9 * 64);
    din_valid = 1;
    cyc();
    din_valid = 0;
    ovf_clr = 1;
    cyc();
    ovf_clr = 0;
    chk("clr_vs_drop", int'(overflow), 1);
    ovf_clr = 1;
    cyc();
    ovf_clr = 0;
    chk("clr_after_drop", int'(overflow), 0);
    dout_ready = 1;
    cyc(8);
    dout_ready = 0;
    chk("drained", int'(count), 0);
    for (int k = 1; k <= 5; k++) send(k * 64);
    cyc(2);
    chk("pre_rst_count", int'(count), 5);
    reset = 0;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(dout_valid), 0);
    chk("mid_rst_sat", int'(sat_cnt), 0);
    cyc();
    reset = 1;
    Din = 18'(7 * 64);
    din_valid = 1;
    cyc();
    din_valid = 0;
    chk("post_rst_edge1", int'(dout_valid), 0);
    cyc();
    chk("post_rst_edge2", int'(dout_valid), 1);
    chk("post_rst_dout", int'(dout), 7);
    cyc(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
